// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the unified memory of the multicycle MIPS core.
// The CPU and debug/loader ports share the memory round-robin; the debug port can lock for bounded bursts.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_dbg
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int          LOCK_W   = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);
  localparam logic [3:0]  LAT      = 4'(MEM_LAT);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;       // 1 = debug owns the current/last access
  logic              last_dbg_q, last_dbg_d; // round-robin pointer, resets to DBG
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic tie, locked_win, pick_dbg;

  assign tie        = cpu_req & dbg_req;
  assign locked_win = tie & last_dbg_q & dbg_lock & (lock_cnt_q < LOCK_MAX);
  assign pick_dbg   = dbg_req & (~cpu_req | ~last_dbg_q | locked_win);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_dbg_d  = last_dbg_q;
    lock_cnt_d  = lock_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (!dbg_lock) lock_cnt_d = '0;
        if (cpu_req || dbg_req) begin
          owner_d   = pick_dbg;
          lat_cnt_d = LAT;
          state_d   = S_ACCESS;
          if (pick_dbg) begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
            if (locked_win) lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end else begin
            we_d       = cpu_we;
            addr_d     = cpu_addr;
            wdata_d    = cpu_wdata;
            lock_cnt_d = '0;
          end
        end
      end
      S_ACCESS: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) begin
          if (owner_q) dbg_rdata_d = mem_rdata;
          else         cpu_rdata_d = mem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_dbg_d = owner_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_dbg_q  <= 1'b1;
      lock_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_dbg_q  <= last_dbg_d;
      lock_cnt_q  <= lock_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Write strobe only in the first access cycle so a multi-cycle access writes once.
  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = mem_en & we_q & (lat_cnt_q == LAT);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = (state_q == S_DONE) & ~owner_q;
  assign dbg_ack   = (state_q == S_DONE) &  owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign grant_dbg = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: instance 0 runs MEM_LAT=1, instance 1 runs MEM_LAT=3, each with a small memory model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst       [2];
  logic        cpu_req   [2];
  logic        cpu_we    [2];
  logic [31:0] cpu_addr  [2];
  logic [31:0] cpu_wdata [2];
  logic        cpu_ack   [2];
  logic [31:0] cpu_rdata [2];
  logic        dbg_req   [2];
  logic        dbg_we    [2];
  logic [31:0] dbg_addr  [2];
  logic [31:0] dbg_wdata [2];
  logic        dbg_lock  [2];
  logic        dbg_ack   [2];
  logic [31:0] dbg_rdata [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];
  logic        grant_dbg [2];

  logic [31:0] mem [2][256];
  int          we_cnt [2];
  int          cyc = 0;
  int          pass_cnt = 0;
  int          tot_cnt = 0;

  typedef struct {
    bit          dbg;
    bit          chk;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_LOCK(8)) u_l1 (
    .clk(clk), .reset(rst[0]),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
    .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_wdata[0]),
    .dbg_lock(dbg_lock[0]), .dbg_ack(dbg_ack[0]), .dbg_rdata(dbg_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .grant_dbg(grant_dbg[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_LOCK(8)) u_l3 (
    .clk(clk), .reset(rst[1]),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
    .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_wdata[1]),
    .dbg_lock(dbg_lock[1]), .dbg_ack(dbg_ack[1]), .dbg_rdata(dbg_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .grant_dbg(grant_dbg[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous-read memory; writes land on the edge ending the strobe cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) mem_rdata[i] = mem[i][mem_addr[i][7:0]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_en[i] && mem_we[i]) begin
        mem[i][mem_addr[i][7:0]] <= mem_wdata[i];
        we_cnt[i] <= we_cnt[i] + 1;
      end
    end
  end

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s inst%0d cyc=%0d: got 0x%0h expected 0x%0h", nm, inst, cyc, act, exp);
  endtask

  task automatic push(input int inst, input bit dbg, input bit chkd, input logic [31:0] d, input int c);
    exp_t e;
    e.dbg = dbg; e.chk = chkd; e.data = d; e.cyc = c;
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  // Monitor: every ack pops the next expected transaction for that instance.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cpu_ack[i] || dbg_ack[i]) begin
        exp_t e;
        bit   got;
        got = 1'b0;
        if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
        else if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
        if (!got) begin
          tot_cnt++;
          $display("FAIL unexpected_ack inst%0d cyc=%0d: cpu_ack=%0b dbg_ack=%0b with none expected",
                   i, cyc, cpu_ack[i], dbg_ack[i]);
        end else begin
          chk("ack_owner", i, {63'd0, dbg_ack[i]}, {63'd0, e.dbg});
          chk("ack_both", i, {63'd0, cpu_ack[i] & dbg_ack[i]}, 64'd0);
          chk("ack_cycle", i, 64'(cyc), 64'(e.cyc));
          if (e.chk)
            chk("ack_rdata", i, {32'd0, (e.dbg ? dbg_rdata[i] : cpu_rdata[i])}, {32'd0, e.data});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    int c;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
      dbg_req[i] = 1'b0; dbg_we[i] = 1'b0; dbg_addr[i] = '0; dbg_wdata[i] = '0; dbg_lock[i] = 1'b0;
      we_cnt[i] = 0;
    end
    step(); step(); step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_cpu_ack", i, {63'd0, cpu_ack[i]}, 64'd0);
      chk("rst_dbg_ack", i, {63'd0, dbg_ack[i]}, 64'd0);
      chk("rst_mem_en", i, {63'd0, mem_en[i]}, 64'd0);
      chk("rst_mem_we", i, {63'd0, mem_we[i]}, 64'd0);
      chk("rst_busy", i, {63'd0, busy[i]}, 64'd0);
      chk("rst_grant_dbg", i, {63'd0, grant_dbg[i]}, 64'd0);
      chk("rst_mem_addr", i, {32'd0, mem_addr[i]}, 64'd0);
      chk("rst_rdata", i, {cpu_rdata[i], dbg_rdata[i]}, 64'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    step();

    // Loader writes 0xDEADBEEF to 0x10 (MEM_LAT=1).
    c = cyc;
    dbg_req[0] = 1'b1; dbg_we[0] = 1'b1; dbg_addr[0] = 32'h10; dbg_wdata[0] = 32'hDEADBEEF;
    push(0, 1'b1, 1'b0, 32'h0, c + 2);
    go_to(c + 2);
    dbg_req[0] = 1'b0; dbg_we[0] = 1'b0;
    step();

    // Single CPU read.
    c = cyc;
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h10;
    push(0, 1'b0, 1'b1, 32'hDEADBEEF, c + 2);
    step();
    chk("read_mem_en", 0, {63'd0, mem_en[0]}, 64'd1);
    chk("read_mem_addr", 0, {32'd0, mem_addr[0]}, 64'h10);
    chk("read_busy", 0, {63'd0, busy[0]}, 64'd1);
    go_to(c + 2);
    cpu_req[0] = 1'b0;
    step();

    // Tie after reset: CPU, DBG, CPU, DBG, acks 3 cycles apart.
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    c = cyc;
    cpu_req[0] = 1'b1; dbg_req[0] = 1'b1; dbg_addr[0] = 32'h10;
    push(0, 1'b0, 1'b1, 32'hDEADBEEF, c + 2);
    push(0, 1'b1, 1'b1, 32'hDEADBEEF, c + 5);
    push(0, 1'b0, 1'b1, 32'hDEADBEEF, c + 8);
    push(0, 1'b1, 1'b1, 32'hDEADBEEF, c + 11);
    go_to(c + 11);
    cpu_req[0] = 1'b0; dbg_req[0] = 1'b0;
    step();

    // Lock burst: DBG was last owner, so 8 locked DBG grants, one CPU slot, then DBG again.
    c = cyc;
    dbg_lock[0] = 1'b1; cpu_req[0] = 1'b1; dbg_req[0] = 1'b1;
    for (int j = 0; j < 8; j++) push(0, 1'b1, 1'b1, 32'hDEADBEEF, c + 2 + 3 * j);
    push(0, 1'b0, 1'b1, 32'hDEADBEEF, c + 26);
    push(0, 1'b1, 1'b1, 32'hDEADBEEF, c + 29);
    go_to(c + 29);
    cpu_req[0] = 1'b0; dbg_req[0] = 1'b0; dbg_lock[0] = 1'b0;
    step();

    // Reset during ACCESS of a CPU read: dropped, then the tie goes to CPU.
    c = cyc;
    cpu_req[0] = 1'b1; cpu_addr[0] = 32'h10;
    step();
    chk("midrst_mem_en_before", 0, {63'd0, mem_en[0]}, 64'd1);
    rst[0] = 1'b1; cpu_req[0] = 1'b0;
    step();
    chk("midrst_mem_en", 0, {63'd0, mem_en[0]}, 64'd0);
    chk("midrst_busy", 0, {63'd0, busy[0]}, 64'd0);
    chk("midrst_cpu_ack", 0, {63'd0, cpu_ack[0]}, 64'd0);
    rst[0] = 1'b0;
    c = cyc;
    cpu_req[0] = 1'b1; dbg_req[0] = 1'b1;
    push(0, 1'b0, 1'b1, 32'hDEADBEEF, c + 2);
    push(0, 1'b1, 1'b1, 32'hDEADBEEF, c + 5);
    go_to(c + 5);
    cpu_req[0] = 1'b0; dbg_req[0] = 1'b0;
    step();

    // MEM_LAT=3: DBG write 0x1234 to 0x40, 5 cycles sample-to-ack.
    c = cyc;
    dbg_req[1] = 1'b1; dbg_we[1] = 1'b1; dbg_addr[1] = 32'h40; dbg_wdata[1] = 32'h0000_1234;
    push(1, 1'b1, 1'b0, 32'h0, c + 4);
    go_to(c + 4);
    dbg_req[1] = 1'b0; dbg_we[1] = 1'b0;
    step();

    // CPU reads it back.
    c = cyc;
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'h40;
    push(1, 1'b0, 1'b1, 32'h0000_1234, c + 4);
    go_to(c + 4);
    cpu_req[1] = 1'b0;
    step();
    chk("write_strobe_count", 1, 64'(we_cnt[1]), 64'd1);
    step(); step(); step();
    chk("rdata_hold", 1, {32'd0, cpu_rdata[1]}, 64'h0000_1234);

    // Held request: second access starts right after DONE, acks MEM_LAT+2 apart.
    c = cyc;
    cpu_req[1] = 1'b1;
    push(1, 1'b0, 1'b1, 32'h0000_1234, c + 4);
    push(1, 1'b0, 1'b1, 32'h0000_1234, c + 9);
    go_to(c + 9);
    cpu_req[1] = 1'b0;
    step(); step(); step(); step();

    chk("inst0_all_acked", 0, 64'(q0.size()), 64'd0);
    chk("inst1_all_acked", 1, 64'(q1.size()), 64'd0);
    chk("inst0_write_count", 0, 64'(we_cnt[0]), 64'd1);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters.
- Requester 1 is the CPU port, driven by the control unit's fetch and load/store states, with the address already selected by IorD.
- Requester 2 is a debug/loader port used for program load and memory inspection.
- Arbitrates round-robin, with an optional bounded lock for loader bursts. It sequences each memory access through a fixed-latency FSM and returns a one-cycle acknowledge that the control unit uses as its stall release.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles (legal range 1..15); also used as the write occupancy
- MAX_LOCK, 8, maximum consecutive debug grants under dbg_lock before the CPU is forced a slot

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request; level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack = 1
- dbg_req  in  1  debug request; level, held until dbg_ack
- dbg_we  in  1  debug write enable
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_lock  in  1  request to keep the grant for back-to-back debug accesses
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  read data, valid while dbg_ack = 1
- mem_en  out  1  memory enable
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the first mem_en cycle
- busy  out  1  high when state is not IDLE
- grant_dbg  out  1  current or last owner (1 = debug)

Behaviour:
- **Reset values:** all outputs 0, state = IDLE, last owner = DBG (so the CPU wins the first tie), lock counter = 0, latency counter = 0.
- **States:** IDLE, ACCESS, DONE.
- **IDLE:**
  - At each edge, sample the requests.
  - If none, stay in IDLE.
  - If exactly one, grant it.
  - If both, grant the requester that was not the last owner, except under lock (below).
  - On a grant, register the winner's we/addr/wdata, load latency counter = MEM_LAT, and go to ACCESS.
- **ACCESS:**
  - mem_en = 1 for the whole state; mem_addr and mem_wdata come from the registered values and stay stable.
  - mem_we = registered we, asserted in the first ACCESS cycle only, so each write happens exactly once.
  - Decrement the counter every cycle. When it reaches 1, capture mem_rdata into the owner's rdata register and go to DONE.
  - ACCESS lasts exactly MEM_LAT cycles.
- **DONE:**
  - The owner's ack = 1 for exactly one cycle; rdata is valid; the other ack stays 0.
  - Go to IDLE and update the last owner.
- **Latency:** a request first sampled at edge k gives mem_en in cycles k+1 .. k+MEM_LAT and ack in cycle k+1+MEM_LAT. Reads and writes have the same timing.
- **Handshake:**
  - The requester must drop req (or present a new transaction) at the edge ending its ack cycle.
  - A req still high in the following IDLE cycle is a new transaction, which permits back-to-back accesses.
  - Changes to addr/wdata/we after the grant are ignored until the next IDLE.
- **Lock:**
  - If the last owner is DBG, dbg_lock = 1 and both requests are high in IDLE, DBG wins while lock counter < MAX_LOCK.
  - The lock counter increments on each locked DBG grant.
  - On reaching MAX_LOCK, the CPU is granted and the counter clears.
  - The counter also clears on any CPU grant, or whenever dbg_lock = 0 in IDLE.
- **Simultaneous events:** a request arriving during ACCESS or DONE waits; there is no pre-emption.
- **Write read-back:** mem_rdata is also captured for writes, but rdata content is don't-care for write acks.
- **rdata hold:** cpu_rdata and dbg_rdata hold their last captured value between acks.
- **Reset mid-operation:**
  - Return to IDLE on the next edge and deassert mem_en, mem_we and both acks.
  - The pending transaction is dropped with no ack.
  - A write that already strobed is not rolled back.

Test Plan:
- **Single CPU read, MEM_LAT = 1:** memory word 0x10 = 0xDEADBEEF, cpu_req with addr 0x10 sampled at edge k -> mem_en in cycle k+1; cpu_ack with cpu_rdata = 0xDEADBEEF in cycle k+2; dbg_ack stays 0.
- **Tie after reset:** cpu_req and dbg_req rise together and stay high -> grant order CPU, DBG, CPU, DBG; acks 3 cycles apart at MEM_LAT = 1.
- **Lock burst, MAX_LOCK = 8:** dbg_lock = 1, DBG is the last owner, both requesting continuously -> 8 consecutive dbg_acks, then one cpu_ack, then DBG resumes.
- **Write then read, MEM_LAT = 3:** DBG write 0x0000_1234 to 0x40, then CPU read of 0x40 -> mem_we high for exactly one cycle; cpu_rdata = 0x0000_1234; each transaction takes 5 cycles from IDLE sample to ack inclusive.
- **Reset mid-operation:** reset asserted during ACCESS of a CPU read -> no cpu_ack; next cycle mem_en = 0 and busy = 0; a subsequent request completes normally with CPU winning the tie.
- **Held request:** cpu_req held high across its ack -> a second identical access begins in the IDLE cycle after DONE; two acks are separated by MEM_LAT + 2 cycles.
